// File: rtl/Pu_fetch_pkg.sv
// Types for the fetch queue: FSM state, queue entry, optional predecode helper.
// Build option: define PU_FETCH_PREDECODE_EN to carry a per-entry branch flag.
package Pu_fetch_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } Fetch_state;

  typedef struct packed {
    Pu_inst::Inst inst;
    logic [31:0]  pc;
`ifdef PU_FETCH_PREDECODE_EN
    logic         is_branch;
`endif
  } Fetch_entry;

`ifdef PU_FETCH_PREDECODE_EN
  // Unconditional/conditional branches plus bclr/bcctr under the XL group.
  function automatic logic is_branch(input Pu_inst::Inst inst);
    logic [5:0] opcd;
    logic [9:0] xo;
    logic       unused_fields;
    opcd          = inst[31:26];
    xo            = inst[10:1];
    unused_fields = ^{inst[25:11], inst[0]};
    return (opcd == Pu_inst::Op_bc) || (opcd == Pu_inst::Op_branch) ||
           ((opcd == Pu_inst::Op_bclr) &&
            ((xo == Pu_inst::Xxop_bclr) || (xo == Pu_inst::Xxop_bcctr)));
  endfunction
`endif

endpackage

// File: rtl/Pu_inst.sv
// Instruction-word types shared by the processing-unit front end:
// the raw word, primary/extended opcode encodings and the canonical NOP.
package Pu_inst;

  typedef logic [31:0] Inst;

  typedef enum logic [5:0] {
    Op_addi   = 6'd14,
    Op_bc     = 6'd16,
    Op_branch = 6'd18,
    Op_bclr   = 6'd19,
    Op_ori    = 6'd24
  } Opcd;

  // Extended opcode field (bits [10:1]) of the XL-form group under Op_bclr.
  typedef enum logic [9:0] {
    Xxop_bclr  = 10'd16,
    Xxop_bcctr = 10'd528
  } Xl_opcd;

  localparam Inst INST_NOP = 32'h6000_0000;

endpackage

// File: rtl/pu_fetch_fifo.sv
// Synchronous FIFO of fetch entries with push, pop, clear and occupancy count.
// Head entry is read combinationally from the registered array.
module pu_fetch_fifo
  import Pu_fetch_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     i_clear,
  input  logic                     i_push,
  input  Fetch_entry               i_data,
  input  logic                     i_pop,
  output logic [$clog2(DEPTH):0]   o_count,
  output Fetch_entry               o_head
);

  localparam int AW = $clog2(DEPTH);

  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;
  Fetch_entry    r_mem [DEPTH];
  logic          w_pop;

  assign w_pop = i_pop && (r_count != '0);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset || i_clear) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({i_push, w_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // NOTE: the storage array is deliberately not reset; validity is defined
  // solely by the pointers and count, so stale contents are never exposed.
  always_ff @(posedge clk) begin
    if (i_push && !i_clear) r_mem[r_wr_ptr] <= i_data;
  end

  assign o_count = r_count;
  assign o_head  = r_mem[r_rd_ptr];

endmodule

// File: rtl/pu_fetch_queue.sv
// Instruction-fetch front end: issues sequential imem requests under a credit
// limit, queues returned words with their PC and handles branch redirects.
// Build option: define PU_FETCH_PREDECODE_EN to add the dec_is_branch output.
module pu_fetch_queue
  import Pu_inst::*;
  import Pu_fetch_pkg::*;
#(
  parameter int          DEPTH           = 4,
  parameter int          MAX_OUTSTANDING = 2,
  parameter logic [31:0] RESET_PC        = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        en,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [29:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        dec_valid,
  output logic [31:0] dec_inst,
  output logic [31:0] dec_pc,
  input  logic        dec_ready,
  output logic        busy
`ifdef PU_FETCH_PREDECODE_EN
  ,output logic       dec_is_branch
`endif
);

  localparam int CW = $clog2(DEPTH) + 1;

  Fetch_state  r_state;
  logic [31:2] r_fetch_pc;
  logic [31:2] r_resp_pc;
  logic [CW-1:0] r_outstanding;
  logic [CW-1:0] r_drop;

  logic [CW-1:0] w_count;
  logic [CW-1:0] w_outstanding_next;
  logic          w_credit;
  logic          w_issue;
  logic          w_push;
  logic          w_pop;
  Fetch_entry    w_push_entry;
  Fetch_entry    w_head;
  logic          w_unused_redirect_lsb;

  assign w_unused_redirect_lsb = ^redirect_pc[1:0];

  // Credit counts in-flight requests against free queue space, so the
  // queue cannot overflow even if every outstanding response is kept.
  assign w_credit = (r_outstanding < CW'(MAX_OUTSTANDING)) &&
                    (({1'b0, w_count} + {1'b0, r_outstanding}) < (CW+1)'(DEPTH));
  assign imem_req  = (r_state == RUN) && en && w_credit;
  assign imem_addr = r_fetch_pc;
  assign w_issue   = imem_req && imem_gnt;

  assign w_outstanding_next = r_outstanding + CW'(w_issue) - CW'(imem_rvalid);

  assign w_push = imem_rvalid && (r_drop == '0) && !redirect;
  assign w_pop  = dec_valid && dec_ready;

  // NOTE: every field is assigned on every pass, so no latch is inferred.
  always_comb begin
    w_push_entry.inst      = imem_rdata;
    w_push_entry.pc        = {r_resp_pc, 2'b00};
`ifdef PU_FETCH_PREDECODE_EN
    w_push_entry.is_branch = is_branch(imem_rdata);
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      case (r_state)
        IDLE:    if (en)  r_state <= RUN;
        RUN:     if (!en) r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  // Redirect overrides issue/response bookkeeping; anything still in flight,
  // including a request granted this cycle, becomes a response to discard.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_fetch_pc    <= RESET_PC[31:2];
      r_resp_pc     <= RESET_PC[31:2];
      r_outstanding <= '0;
      r_drop        <= '0;
    end else begin
      r_outstanding <= w_outstanding_next;
      if (redirect) begin
        r_fetch_pc <= redirect_pc[31:2];
        r_resp_pc  <= redirect_pc[31:2];
        r_drop     <= w_outstanding_next;
      end else begin
        if (w_issue) r_fetch_pc <= r_fetch_pc + 30'd1;
        if (imem_rvalid) begin
          if (r_drop != '0) r_drop    <= r_drop - CW'(1);
          else              r_resp_pc <= r_resp_pc + 30'd1;
        end
      end
    end
  end

  pu_fetch_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_clear (redirect),
    .i_push  (w_push),
    .i_data  (w_push_entry),
    .i_pop   (w_pop),
    .o_count (w_count),
    .o_head  (w_head)
  );

  assign dec_valid = (w_count != '0);
  assign dec_inst  = dec_valid ? w_head.inst : INST_NOP;
  assign dec_pc    = dec_valid ? w_head.pc   : 32'h0;
  assign busy      = (r_outstanding != '0) || dec_valid;

`ifdef PU_FETCH_PREDECODE_EN
  assign dec_is_branch = dec_valid && w_head.is_branch;
`endif

endmodule
